// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: datapath width, reset PC, PC step and the
// bubble encoding used by every pipeline register.
package fetch_stage_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned CNT_W   = 16;

    // A bubble is an all-zero instruction word marked not valid.
    localparam logic [WORD_W-1:0] BUBBLE_INSTR = '0;
    localparam logic              BUBBLE_VALID = 1'b0;

    // Per-edge action of the fetch stage, listed in priority order.
    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_BRANCH,
        ACT_FREEZE,
        ACT_RUN
    } fetch_act_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: the fetch stage drives the address, memory
// returns the word combinationally in the same cycle.
interface fetch_stage_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter for performance monitoring; sticks at all-ones
// until a synchronous reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and
// the IF/ID pipeline register, with stall and flush performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       WORD_W   = fetch_stage_pkg::WORD_W,
    parameter logic [WORD_W-1:0] RESET_PC = fetch_stage_pkg::RESET_PC,
    parameter int unsigned       CNT_W    = fetch_stage_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [WORD_W-1:0]  branch_addr,
    fetch_stage_if.master      imem,
    output logic [WORD_W-1:0]  if_id_pc,
    output logic [WORD_W-1:0]  if_id_instr,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] branch_target;
    fetch_act_e        act;

    assign imem.imem_addr = pc;
    assign pc_next        = pc + WORD_W'(PC_STEP);
    // Low two bits are masked off so the PC can never become misaligned.
    assign branch_target  = branch_addr & ~WORD_W'(2'b11);

    // Branch outranks freeze: the branch is older than the stalled instruction.
    always_comb begin
        act = ACT_RUN;
        if (rst) begin
            act = ACT_RESET;
        end else if (branch_taken) begin
            act = ACT_BRANCH;
        end else if (freeze) begin
            act = ACT_FREEZE;
        end
    end

    always_ff @(posedge clk) begin
        case (act)
            ACT_RESET: begin
                pc          <= RESET_PC;
                if_id_pc    <= '0;
                if_id_instr <= WORD_W'(BUBBLE_INSTR);
                if_id_valid <= BUBBLE_VALID;
            end
            ACT_BRANCH: begin
                pc          <= branch_target;
                if_id_pc    <= '0;
                if_id_instr <= WORD_W'(BUBBLE_INSTR);
                if_id_valid <= BUBBLE_VALID;
            end
            ACT_FREEZE: begin
                pc          <= pc;
                if_id_pc    <= if_id_pc;
                if_id_instr <= if_id_instr;
                if_id_valid <= if_id_valid;
            end
            default: begin
                pc          <= pc_next;
                if_id_pc    <= pc_next;
                if_id_instr <= imem.imem_rdata;
                if_id_valid <= 1'b1;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_FREEZE),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_BRANCH),
        .count (flush_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step pushes the predicted post-edge
// state onto a scoreboard queue, which is popped and checked after the edge.
module tb_fetch_stage;

    localparam int unsigned W = 32;
    localparam int unsigned C = 16;

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] ipc;
        logic [W-1:0] instr;
        logic         valid;
        logic [C-1:0] stall;
        logic [C-1:0] flush;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         freeze = 1'b0;
    logic         branch_taken = 1'b0;
    logic [W-1:0] branch_addr = '0;
    logic [W-1:0] if_id_pc;
    logic [W-1:0] if_id_instr;
    logic         if_id_valid;
    logic [C-1:0] stall_count;
    logic [C-1:0] flush_count;

    fetch_stage_if #(.WORD_W(W)) bus ();

    fetch_stage #(
        .WORD_W   (W),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus.master),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    // Reference state of the fetch stage.
    logic [W-1:0] m_pc    = 'x;
    logic [W-1:0] m_ipc   = 'x;
    logic [W-1:0] m_instr = 'x;
    logic         m_valid = 1'bx;
    logic [C-1:0] m_stall = 'x;
    logic [C-1:0] m_flush = 'x;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic b,
                        input logic [W-1:0] addr, input logic [W-1:0] rdata,
                        input bit chk);
        exp_t e;
        rst = r; freeze = f; branch_taken = b; branch_addr = addr;
        bus.imem_rdata = rdata;
        if (r) begin
            m_pc = 32'h0; m_ipc = '0; m_instr = '0; m_valid = 1'b0;
            m_stall = '0; m_flush = '0;
        end else if (b) begin
            m_pc = {addr[W-1:2], 2'b00}; m_ipc = '0; m_instr = '0; m_valid = 1'b0;
            if (m_flush != {C{1'b1}}) m_flush = m_flush + 1'b1;
        end else if (f) begin
            if (m_stall != {C{1'b1}}) m_stall = m_stall + 1'b1;
        end else begin
            m_instr = rdata; m_pc = m_pc + 32'd4; m_ipc = m_pc; m_valid = 1'b1;
        end
        e = '{m_pc, m_ipc, m_instr, m_valid, m_stall, m_flush};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (chk) begin
            check("sb_addr",  bus.imem_addr, e.addr);
            check("sb_ipc",   if_id_pc,      e.ipc);
            check("sb_instr", if_id_instr,   e.instr);
            check("sb_valid", W'(if_id_valid), W'(e.valid));
            check("sb_stall", W'(stall_count), W'(e.stall));
            check("sb_flush", W'(flush_count), W'(e.flush));
        end
    endtask

    logic [W-1:0] held_instr;

    initial begin
        bus.imem_rdata = '0;

        // Reset
        step(1, 0, 0, '0, '0, 1);
        check("rst_addr",  bus.imem_addr, 32'h0);
        check("rst_valid", W'(if_id_valid), 32'h0);
        check("rst_stall", W'(stall_count), 32'h0);

        // Three free-running fetches
        step(0, 0, 0, '0, 32'hE3A0_0001, 1);
        check("run1_addr", bus.imem_addr, 32'h4);
        step(0, 0, 0, '0, 32'hE3A0_0001, 1);
        check("run2_addr", bus.imem_addr, 32'h8);
        step(0, 0, 0, '0, 32'hE3A0_0001, 1);
        check("run3_addr",  bus.imem_addr, 32'hC);
        check("run3_ipc",   if_id_pc, 32'hC);
        check("run3_valid", W'(if_id_valid), 32'h1);
        check("run3_instr", if_id_instr, 32'hE3A0_0001);

        // Fetch up to pc = 16, then freeze three cycles
        step(0, 0, 0, '0, 32'hE1A0_2003, 1);
        check("pre_frz_addr", bus.imem_addr, 32'h10);
        held_instr = if_id_instr;
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0, $urandom, 1);
        check("frz_addr",  bus.imem_addr, 32'h10);
        check("frz_instr", if_id_instr, held_instr);
        check("frz_ipc",   if_id_pc, 32'h10);
        check("frz_stall", W'(stall_count), 32'd3);
        step(0, 0, 0, '0, 32'hE280_1001, 1);
        check("rel_ipc", if_id_pc, 32'h14);

        // Taken branch with unaligned target
        step(0, 0, 1, 32'h0000_0103, $urandom, 1);
        check("br_addr",  bus.imem_addr, 32'h100);
        check("br_valid", W'(if_id_valid), 32'h0);
        check("br_flush", W'(flush_count), 32'd1);
        step(0, 0, 0, '0, 32'hEAFF_FFFE, 1);
        check("br_tgt_ipc",   if_id_pc, 32'h104);
        check("br_tgt_instr", if_id_instr, 32'hEAFF_FFFE);

        // Branch and freeze together: branch wins, no stall counted
        step(0, 1, 1, 32'h0000_0200, $urandom, 1);
        check("bf_addr",  bus.imem_addr, 32'h200);
        check("bf_stall", W'(stall_count), 32'd3);
        check("bf_flush", W'(flush_count), 32'd2);

        // A few random free fetches
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, $urandom, 1);

        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFF, $urandom, 1);
        check("wrap_pre", bus.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, '0, 32'h1234_5678, 1);
        check("wrap_addr",  bus.imem_addr, 32'h0);
        check("wrap_ipc",   if_id_pc, 32'h0);
        check("wrap_valid", W'(if_id_valid), 32'h1);

        // Long freeze saturates stall_count
        for (int i = 0; i < (1 << C) + 5; i++) step(0, 1, 0, '0, $urandom, 0);
        check("sat_stall", W'(stall_count), 32'h0000_FFFF);
        step(0, 1, 0, '0, $urandom, 1);
        check("sat_hold",  W'(stall_count), 32'h0000_FFFF);
        check("sat_addr",  bus.imem_addr, 32'h0);

        // Reset during freeze
        step(1, 1, 0, '0, $urandom, 1);
        check("rst2_addr",  bus.imem_addr, 32'h0);
        check("rst2_ipc",   if_id_pc, 32'h0);
        check("rst2_instr", if_id_instr, 32'h0);
        check("rst2_stall", W'(stall_count), 32'h0);
        check("rst2_flush", W'(flush_count), 32'h0);

        // Reset during a branch, then first fetch from RESET_PC
        step(1, 0, 1, 32'h0000_0400, $urandom, 1);
        check("rst3_flush", W'(flush_count), 32'h0);
        step(0, 0, 0, '0, 32'hE3A0_0005, 1);
        check("post_rst_ipc",   if_id_pc, 32'h4);
        check("post_rst_instr", if_id_instr, 32'hE3A0_0005);

        tests++;
        assert (sb.size() == 0) else begin
            failed++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
